// File: rtl/flash_cmd_decoder.sv
// flash_cmd_decoder
//
// SPI-flash slave command decoder, clocked on sck_i. It takes the received byte
// stream plus a two-deep history of earlier bytes from the pre-shift stage. It
// decodes the opcode and assembles the 24-bit start address. It then issues
// read, page-program, sector-erase and status requests to the array controller.
// It also holds the write-enable latch.
//
// Optional feature: define FLASH_FAST_READ_EN to decode opcode 0x0B as
// FAST_READ (address, one dummy byte, then read stream). Without the macro,
// 0x0B is an unknown opcode.
//
// Ports:
//   sck_i            SPI clock, all state updates on its rising edge
//   rst_ni           asynchronous active-low reset
//   cs_ni            chip select (active low), sampled on sck_i
//   data_byte_in_i   current received byte
//   data_in_valid_i  data_byte_in_i valid this cycle
//   pre_data1_i      byte received one valid-cycle earlier
//   pre_data2_i      byte received two valid-cycles earlier
//   cmd_opcode_o     latched opcode of the current/last frame
//   cmd_addr_o       assembled start address
//   addr_valid_o     1-cycle pulse when the address is complete
//   rd_req_o         1-cycle pulse per array read request
//   rd_addr_o        address for rd_req_o
//   pp_we_o          1-cycle pulse per program data byte
//   pp_addr_o        address for pp_we_o
//   pp_data_o        data for pp_we_o
//   se_req_o         1-cycle sector-erase commit pulse
//   status_sel_o     high while an RDSR frame is active
//   wel_o            write-enable latch
//   cmd_err_o        1-cycle error pulse
module flash_cmd_decoder #(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned PAGE_SIZE = 256
) (
  input  logic              sck_i,
  input  logic              rst_ni,
  input  logic              cs_ni,
  input  logic [7:0]        data_byte_in_i,
  input  logic              data_in_valid_i,
  input  logic [7:0]        pre_data1_i,
  input  logic [7:0]        pre_data2_i,
  output logic [7:0]        cmd_opcode_o,
  output logic [ADDR_W-1:0] cmd_addr_o,
  output logic              addr_valid_o,
  output logic              rd_req_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              pp_we_o,
  output logic [ADDR_W-1:0] pp_addr_o,
  output logic [7:0]        pp_data_o,
  output logic              se_req_o,
  output logic              status_sel_o,
  output logic              wel_o,
  output logic              cmd_err_o
);

  localparam int unsigned PageW = $clog2(PAGE_SIZE);

  localparam logic [7:0] OpcRead     = 8'h03;
  localparam logic [7:0] OpcPp       = 8'h02;
  localparam logic [7:0] OpcSe       = 8'h20;
  localparam logic [7:0] OpcWren     = 8'h06;
  localparam logic [7:0] OpcWrdi     = 8'h04;
  localparam logic [7:0] OpcRdsr     = 8'h05;
`ifdef FLASH_FAST_READ_EN
  localparam logic [7:0] OpcFastRead = 8'h0B;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StDummy,
    StData,
    StIgnore
  } state_e;

  // Decoded command class of the current frame; drives both the data phase
  // and the commit taken when cs_ni rises.
  typedef enum logic [2:0] {
    OpNone,
    OpRead,
    OpFastRead,
    OpPp,
    OpSe,
    OpWren,
    OpWrdi,
    OpRdsr
  } op_e;

  state_e             state_q;
  op_e                op_q;
  logic [1:0]         addr_cnt_q;
  logic               addr_done_q;
  // Set once the first program data byte of a PP frame has been seen.
  logic               pp_seen_q;
  logic [PageW-1:0]   page_off_q;

  logic [7:0]         cmd_opcode_q;
  logic [ADDR_W-1:0]  cmd_addr_q;
  logic               addr_valid_q;
  logic               rd_req_q;
  logic [ADDR_W-1:0]  rd_addr_q;
  logic               pp_we_q;
  logic [ADDR_W-1:0]  pp_addr_q;
  logic [7:0]         pp_data_q;
  logic               se_req_q;
  logic               status_sel_q;
  logic               wel_q;
  logic               cmd_err_q;

  always_ff @(posedge sck_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      op_q         <= OpNone;
      addr_cnt_q   <= 2'd0;
      addr_done_q  <= 1'b0;
      pp_seen_q    <= 1'b0;
      page_off_q   <= '0;
      cmd_opcode_q <= 8'h00;
      cmd_addr_q   <= '0;
      addr_valid_q <= 1'b0;
      rd_req_q     <= 1'b0;
      rd_addr_q    <= '0;
      pp_we_q      <= 1'b0;
      pp_addr_q    <= '0;
      pp_data_q    <= 8'h00;
      se_req_q     <= 1'b0;
      status_sel_q <= 1'b0;
      wel_q        <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      // Pulse outputs default low every edge.
      addr_valid_q <= 1'b0;
      rd_req_q     <= 1'b0;
      pp_we_q      <= 1'b0;
      se_req_q     <= 1'b0;
      cmd_err_q    <= 1'b0;

      if (cs_ni) begin
        // Deselect ends the frame; any byte on this edge is dropped. A
        // non-idle state means a frame was in progress, so commit it now.
        state_q      <= StIdle;
        status_sel_q <= 1'b0;
        if (state_q != StIdle) begin
          unique case (op_q)
            OpWren: wel_q <= 1'b1;
            OpWrdi: wel_q <= 1'b0;
            OpSe: begin
              if (!addr_done_q || !wel_q) begin
                cmd_err_q <= 1'b1;
              end else begin
                se_req_q <= 1'b1;
                wel_q    <= 1'b0;
              end
            end
            OpPp: begin
              if (!addr_done_q) begin
                cmd_err_q <= 1'b1;
              end else if (pp_seen_q && wel_q) begin
                wel_q <= 1'b0;
              end
            end
            OpRead, OpFastRead: begin
              if (!addr_done_q) begin
                cmd_err_q <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end else if (data_in_valid_i) begin
        unique case (state_q)
          StIdle: begin
            cmd_opcode_q <= data_byte_in_i;
            addr_cnt_q   <= 2'd0;
            addr_done_q  <= 1'b0;
            pp_seen_q    <= 1'b0;
            unique case (data_byte_in_i)
              OpcRead: begin
                op_q    <= OpRead;
                state_q <= StAddr;
              end
`ifdef FLASH_FAST_READ_EN
              OpcFastRead: begin
                op_q    <= OpFastRead;
                state_q <= StAddr;
              end
`endif
              OpcPp: begin
                op_q    <= OpPp;
                state_q <= StAddr;
              end
              OpcSe: begin
                op_q    <= OpSe;
                state_q <= StAddr;
              end
              OpcWren: begin
                op_q    <= OpWren;
                state_q <= StIgnore;
              end
              OpcWrdi: begin
                op_q    <= OpWrdi;
                state_q <= StIgnore;
              end
              OpcRdsr: begin
                op_q         <= OpRdsr;
                status_sel_q <= 1'b1;
                state_q      <= StIgnore;
              end
              default: begin
                op_q      <= OpNone;
                cmd_err_q <= 1'b1;
                state_q   <= StIgnore;
              end
            endcase
          end

          StAddr: begin
            addr_cnt_q <= addr_cnt_q + 2'd1;
            if (addr_cnt_q == 2'd2) begin
              // Third address byte: the two earlier ones sit in the history.
              cmd_addr_q   <= {pre_data2_i, pre_data1_i, data_byte_in_i};
              addr_valid_q <= 1'b1;
              addr_done_q  <= 1'b1;
              unique case (op_q)
                OpRead: begin
                  state_q   <= StData;
                  rd_req_q  <= 1'b1;
                  rd_addr_q <= {pre_data2_i, pre_data1_i, data_byte_in_i};
                end
                OpFastRead: state_q <= StDummy;
                OpPp: begin
                  state_q    <= StData;
                  page_off_q <= data_byte_in_i[PageW-1:0];
                end
                default: state_q <= StIgnore;
              endcase
            end
          end

          StDummy: begin
            // The dummy byte itself produces no read; the first read is
            // issued as the stream enters the data phase.
            state_q   <= StData;
            rd_req_q  <= 1'b1;
            rd_addr_q <= cmd_addr_q;
          end

          StData: begin
            if (op_q == OpPp) begin
              pp_seen_q <= 1'b1;
              if (wel_q) begin
                pp_we_q    <= 1'b1;
                pp_data_q  <= data_byte_in_i;
                pp_addr_q  <= {cmd_addr_q[ADDR_W-1:PageW], page_off_q};
                // Offset wraps inside the page rather than carrying upward.
                page_off_q <= page_off_q + 1'b1;
              end else if (!pp_seen_q) begin
                cmd_err_q <= 1'b1;
              end
            end else begin
              rd_req_q  <= 1'b1;
              rd_addr_q <= rd_addr_q + 1'b1;
            end
          end

          StIgnore: ;

          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign cmd_opcode_o = cmd_opcode_q;
  assign cmd_addr_o   = cmd_addr_q;
  assign addr_valid_o = addr_valid_q;
  assign rd_req_o     = rd_req_q;
  assign rd_addr_o    = rd_addr_q;
  assign pp_we_o      = pp_we_q;
  assign pp_addr_o    = pp_addr_q;
  assign pp_data_o    = pp_data_q;
  assign se_req_o     = se_req_q;
  assign status_sel_o = status_sel_q;
  assign wel_o        = wel_q;
  assign cmd_err_o    = cmd_err_q;

endmodule

// File: tb/tb_flash_cmd_decoder.sv
// Testbench for flash_cmd_decoder: directed frames from the command set,
// then randomized frames, all checked every cycle against a frame-level
// reference model that works on byte positions within the frame.
module tb_flash_cmd_decoder;

`ifdef FLASH_FAST_READ_EN
  localparam bit FastEn = 1'b1;
`else
  localparam bit FastEn = 1'b0;
`endif

  logic        sck;
  logic        rst_n;
  logic        cs_n;
  logic [7:0]  data_byte_in;
  logic        data_in_valid;
  logic [7:0]  pre_data1;
  logic [7:0]  pre_data2;
  logic [7:0]  cmd_opcode;
  logic [23:0] cmd_addr;
  logic        addr_valid;
  logic        rd_req;
  logic [23:0] rd_addr;
  logic        pp_we;
  logic [23:0] pp_addr;
  logic [7:0]  pp_data;
  logic        se_req;
  logic        status_sel;
  logic        wel;
  logic        cmd_err;

  flash_cmd_decoder #(
    .ADDR_W   (24),
    .PAGE_SIZE(256)
  ) dut (
    .sck_i          (sck),
    .rst_ni         (rst_n),
    .cs_ni          (cs_n),
    .data_byte_in_i (data_byte_in),
    .data_in_valid_i(data_in_valid),
    .pre_data1_i    (pre_data1),
    .pre_data2_i    (pre_data2),
    .cmd_opcode_o   (cmd_opcode),
    .cmd_addr_o     (cmd_addr),
    .addr_valid_o   (addr_valid),
    .rd_req_o       (rd_req),
    .rd_addr_o      (rd_addr),
    .pp_we_o        (pp_we),
    .pp_addr_o      (pp_addr),
    .pp_data_o      (pp_data),
    .se_req_o       (se_req),
    .status_sel_o   (status_sel),
    .wel_o          (wel),
    .cmd_err_o      (cmd_err)
  );

  initial sck = 1'b0;
  always #5 sck = ~sck;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: bytes of the frame in progress plus held outputs.
  logic [7:0]  fr[$];
  logic [7:0]  m_opcode;
  logic [23:0] m_cmd_addr;
  logic [23:0] m_rd_addr;
  logic [23:0] m_pp_addr;
  logic [7:0]  m_pp_data;
  logic        m_status;
  logic        m_wel;
  logic        e_av, e_rd, e_pp, e_se, e_err;

  // Byte history as the pre-shift stage would present it.
  logic [7:0]  h1, h2;

  function automatic bit known_op(input logic [7:0] op);
    return op == 8'h03 || op == 8'h02 || op == 8'h20 || op == 8'h06 ||
           op == 8'h04 || op == 8'h05 || (FastEn && op == 8'h0B);
  endfunction

  function automatic bit addr_op(input logic [7:0] op);
    return op == 8'h03 || op == 8'h02 || op == 8'h20 || (FastEn && op == 8'h0B);
  endfunction

  task automatic model_reset();
    fr.delete();
    m_opcode = 0; m_cmd_addr = 0; m_rd_addr = 0; m_pp_addr = 0; m_pp_data = 0;
    m_status = 0; m_wel = 0;
    e_av = 0; e_rd = 0; e_pp = 0; e_se = 0; e_err = 0;
  endtask

  task automatic model_step(input logic cs, input logic v, input logic [7:0] b);
    int n;
    int idx;
    logic [7:0] op;
    e_av = 0; e_rd = 0; e_pp = 0; e_se = 0; e_err = 0;
    if (cs) begin
      n = fr.size();
      if (n > 0) begin
        op = fr[0];
        if (op == 8'h06) m_wel = 1'b1;
        else if (op == 8'h04) m_wel = 1'b0;
        else if (op == 8'h20) begin
          if (n < 4 || !m_wel) e_err = 1'b1;
          else begin e_se = 1'b1; m_wel = 1'b0; end
        end else if (op == 8'h02) begin
          if (n < 4) e_err = 1'b1;
          else if (n > 4 && m_wel) m_wel = 1'b0;
        end else if (addr_op(op) && n < 4) e_err = 1'b1;
      end
      fr.delete();
      m_status = 1'b0;
    end else if (v) begin
      fr.push_back(b);
      idx = fr.size() - 1;
      op  = fr[0];
      if (idx == 0) begin
        m_opcode = b;
        if (b == 8'h05) m_status = 1'b1;
        if (!known_op(b)) e_err = 1'b1;
      end else if (addr_op(op) && idx == 3) begin
        m_cmd_addr = {fr[1], fr[2], fr[3]};
        e_av = 1'b1;
        if (op == 8'h03) begin e_rd = 1'b1; m_rd_addr = m_cmd_addr; end
      end else if (idx > 3) begin
        if (op == 8'h03) begin
          e_rd = 1'b1; m_rd_addr = m_cmd_addr + 24'(idx - 3);
        end else if (FastEn && op == 8'h0B) begin
          e_rd = 1'b1; m_rd_addr = m_cmd_addr + 24'(idx - 4);
        end else if (op == 8'h02) begin
          if (m_wel) begin
            e_pp = 1'b1; m_pp_data = b;
            m_pp_addr = {m_cmd_addr[23:8], 8'(m_cmd_addr[7:0] + 8'(idx - 4))};
          end else if (idx == 4) e_err = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("cmd_opcode", 32'(cmd_opcode), 32'(m_opcode));
    check("cmd_addr",   32'(cmd_addr),   32'(m_cmd_addr));
    check("addr_valid", 32'(addr_valid), 32'(e_av));
    check("rd_req",     32'(rd_req),     32'(e_rd));
    check("rd_addr",    32'(rd_addr),    32'(m_rd_addr));
    check("pp_we",      32'(pp_we),      32'(e_pp));
    check("pp_addr",    32'(pp_addr),    32'(m_pp_addr));
    check("pp_data",    32'(pp_data),    32'(m_pp_data));
    check("se_req",     32'(se_req),     32'(e_se));
    check("status_sel", 32'(status_sel), 32'(m_status));
    check("wel",        32'(wel),        32'(m_wel));
    check("cmd_err",    32'(cmd_err),    32'(e_err));
  endtask

  task automatic step(input logic cs, input logic v, input logic [7:0] b);
    cs_n = cs; data_in_valid = v; data_byte_in = b;
    pre_data1 = h1; pre_data2 = h2;
    model_step(cs, v, b);
    @(posedge sck);
    if (!cs && v) begin h2 = h1; h1 = b; end
    #1;
    compare_all();
  endtask

  logic [7:0] tx[8];
  int         tx_n;

  task automatic set_tx(input int n, input logic [7:0] b0 = 0, input logic [7:0] b1 = 0,
                        input logic [7:0] b2 = 0, input logic [7:0] b3 = 0,
                        input logic [7:0] b4 = 0, input logic [7:0] b5 = 0,
                        input logic [7:0] b6 = 0, input logic [7:0] b7 = 0);
    tx_n = n;
    tx[0] = b0; tx[1] = b1; tx[2] = b2; tx[3] = b3;
    tx[4] = b4; tx[5] = b5; tx[6] = b6; tx[7] = b7;
  endtask

  // Sends tx[0..tx_n-1] with optional idle gaps, then deselects. Deselect
  // cycles sometimes carry a stray valid byte, which must be dropped.
  task automatic send_frame(input int gap_pct, input bit close = 1'b1);
    for (int i = 0; i < tx_n; i++) begin
      while ($urandom_range(99) < gap_pct) step(1'b0, 1'b0, 8'($urandom));
      step(1'b0, 1'b1, tx[i]);
    end
    if (close) begin
      step(1'b1, 1'($urandom_range(1)), 8'($urandom));
      if ($urandom_range(1) == 1) step(1'b1, 1'b0, 8'h00);
    end
  endtask

  initial begin
    rst_n = 1'b1; cs_n = 1'b1; data_in_valid = 1'b0; data_byte_in = 8'h00;
    pre_data1 = 8'h00; pre_data2 = 8'h00; h1 = 8'h00; h2 = 8'h00;
    model_reset();
    #2 rst_n = 1'b0;
    #1 compare_all();
    @(negedge sck) rst_n = 1'b1;
    step(1'b1, 1'b0, 8'h00);

    // Write enable / disable.
    set_tx(1, 8'h06);                                     send_frame(0);
    set_tx(1, 8'h04);                                     send_frame(0);
    // Read with streaming.
    set_tx(6, 8'h03, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00);  send_frame(30);
    // Page program wrapping inside the page.
    set_tx(1, 8'h06);                                     send_frame(0);
    set_tx(7, 8'h02, 8'h00, 8'h10, 8'hFE, 8'hAA, 8'hBB, 8'hCC); send_frame(20);
    // Sector erase without and with write enable.
    set_tx(4, 8'h20, 8'h01, 8'h00, 8'h00);                send_frame(0);
    set_tx(1, 8'h06);                                     send_frame(0);
    set_tx(4, 8'h20, 8'h01, 8'h00, 8'h00);                send_frame(0);
    // Error paths.
    set_tx(2, 8'h5A, 8'h11);                              send_frame(0);
    set_tx(2, 8'h03, 8'hAB);                              send_frame(0);
    set_tx(6, 8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22); send_frame(0);
    // Read address wrap and status read.
    set_tx(6, 8'h03, 8'hFF, 8'hFF, 8'hFE, 8'h01, 8'h02);  send_frame(0);
    set_tx(3, 8'h05, 8'h00, 8'h00);                       send_frame(0);
    // Fast read (or unknown opcode when the feature is off).
    set_tx(6, 8'h0B, 8'h00, 8'h00, 8'h20, 8'hFF, 8'h11);  send_frame(0);

    // Reset mid page-program: everything clears immediately.
    set_tx(1, 8'h06);                                     send_frame(0);
    set_tx(6, 8'h02, 8'h00, 8'h20, 8'h00, 8'h55, 8'h66);  send_frame(0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1 compare_all();
    @(negedge sck) rst_n = 1'b1;
    step(1'b1, 1'b0, 8'h00);

    // Randomized frames.
    for (int f = 0; f < 300; f++) begin
      logic [7:0] ops[8];
      ops = '{8'h03, 8'h02, 8'h20, 8'h06, 8'h04, 8'h05, 8'h0B, 8'h06};
      tx_n = $urandom_range(1, 8);
      tx[0] = ops[$urandom_range(7)];
      if ($urandom_range(9) == 0) tx[0] = 8'($urandom);
      for (int i = 1; i < 8; i++) tx[i] = 8'($urandom);
      if ($urandom_range(3) == 0) tx[3] = 8'hFC + 8'($urandom_range(3));
      if ($urandom_range(7) == 0) begin tx[1] = 8'hFF; tx[2] = 8'hFF; end
      send_frame(25);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/flash_cmd_decoder.md
Name: flash_cmd_decoder

Overview:
- SPI-flash slave command decoder, clocked on sck.
- Consumes the byte stream (data_byte_in / data_in_valid) and the two-deep byte history (pre_data1 = previous byte, pre_data2 = byte before that) from the pre-shift register stage.
- Decodes opcode, assembles the 24-bit address, and issues read, page-program, sector-erase and status requests to the memory/array controller.
- Maintains the write-enable latch (WEL).

Parameters:
ADDR_W, 24, address width; fixed at 3 address bytes.
PAGE_SIZE, 256, page-program wrap boundary in bytes; power of 2.

Ports:
sck  input  1  SPI clock; all state updates on its rising edge.
rst_n  input  1  asynchronous active-low reset.
cs_n  input  1  chip select, active low; sampled synchronously on sck.
data_byte_in  input  8  current received byte.
data_in_valid  input  1  data_byte_in valid this cycle.
pre_data1  input  8  byte received one valid-cycle earlier.
pre_data2  input  8  byte received two valid-cycles earlier.
cmd_opcode  output  8  latched opcode of current/last frame.
cmd_addr  output  ADDR_W  assembled start address.
addr_valid  output  1  1-cycle pulse when address complete.
rd_req  output  1  1-cycle pulse per array read request.
rd_addr  output  ADDR_W  address for rd_req.
pp_we  output  1  1-cycle pulse per program data byte.
pp_addr  output  ADDR_W  address for pp_we.
pp_data  output  8  data for pp_we.
se_req  output  1  1-cycle sector-erase commit pulse.
status_sel  output  1  high while an RDSR frame is active.
wel  output  1  write-enable latch.
cmd_err  output  1  1-cycle error pulse.

Behaviour:
- Reset: every output is 0; FSM is in IDLE.
  - Reset is asynchronous. Asserting it mid-frame aborts with no pulses and clears wel.
- All outputs are registered. A pulse appears the sck edge after the sampled data_in_valid or cs_n event.
- cs_n high on any edge:
  - FSM returns to IDLE.
  - data_in_valid on that same edge is ignored.
  - Commit actions below are evaluated on that edge.
- FSM states: IDLE, ADDR, DUMMY, DATA, IGNORE.
  - IDLE:
    - First valid byte with cs_n low latches cmd_opcode.
    - 0x03 READ, 0x02 PP, 0x20 SE go to ADDR with addr_cnt = 0.
    - 0x06 WREN, 0x04 WRDI go to IGNORE; their action is taken at cs_n rise.
    - 0x05 RDSR sets status_sel and goes to IGNORE.
    - Any other opcode pulses cmd_err and goes to IGNORE.
  - ADDR:
    - addr_cnt increments on each valid byte.
    - On the third valid byte: cmd_addr = {pre_data2, pre_data1, data_byte_in}, and addr_valid pulses.
    - Then: READ goes to DATA with rd_req pulsed and rd_addr = cmd_addr. PP goes to DATA. SE goes to IGNORE.
  - DATA, READ: each further valid byte (dummy clocking) increments rd_addr by 1 and pulses rd_req. rd_addr wraps 0xFFFFFF to 0x000000.
  - DATA, PP: each valid byte pulses pp_we.
    - pp_data = byte.
    - pp_addr = {cmd_addr[23:8], page_off}. page_off starts at cmd_addr[7:0] and increments mod PAGE_SIZE (wraps within the page).
    - If wel = 0, no pp_we is issued; cmd_err pulses once at the first data byte.
  - IGNORE: valid bytes are discarded.
- Commit on cs_n rise:
  - WREN sets wel; WRDI clears wel.
  - SE with addr complete and wel = 1 pulses se_req and clears wel.
  - SE with wel = 0 pulses cmd_err.
  - PP with at least one data byte and wel = 1 clears wel.
  - READ/PP/SE ended before addr complete pulses cmd_err; no other action.
  - status_sel clears.
- No data_in_valid in any state leaves the state unchanged.

Optional Feature:
FLASH_FAST_READ_EN:
- When defined: opcode 0x0B is FAST_READ. It goes to ADDR and, after the address, to DUMMY.
  - DUMMY consumes exactly one valid byte without rd_req, then goes to DATA.
  - On entry to DATA it issues rd_req with rd_addr = cmd_addr, then behaves as READ.
- When undefined: 0x0B is an unknown opcode (cmd_err, IGNORE).

Test Plan:
- Reset then WREN: bytes 0x06, then cs_n high -> wel = 1, no cmd_err; second frame 0x04 -> wel = 0.
- READ: 0x03, 0x12, 0x34, 0x56, 2 more bytes -> addr_valid with cmd_addr = 0x123456; rd_req x3 with rd_addr 0x123456, 0x123457, 0x123458.
- Page-program wrap: WREN frame, then 0x02, 0x00, 0x10, 0xFE, data 0xAA, 0xBB, 0xCC -> pp_we x3, pp_addr 0x0010FE, 0x0010FF, 0x001000; pp_data matches; wel = 0 after cs_n.
- SE without WEL: 0x20, 0x01, 0x00, 0x00, cs_n high -> no se_req, cmd_err pulse. With a preceding WREN frame -> se_req pulse, wel cleared.
- Error paths: opcode 0x5A -> cmd_err. READ with 0x03, 0xAB then cs_n high -> cmd_err, no addr_valid. rst_n low mid-PP -> all outputs 0 immediately.
- FLASH_FAST_READ_EN defined: 0x0B, 0x00, 0x00, 0x20, dummy 0xFF -> first rd_req with rd_addr 0x000020 only after the dummy byte. Undefined -> cmd_err.
